// File: rtl/dct_row_mac.sv
// 8-point 1-D DCT row engine: loads 8 samples, then one 9-cycle MAC pass per output k.
// Optional input level shift (in_data - 128) is enabled by defining DCT_LEVEL_SHIFT_EN.
module dct_row_mac (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic [2:0]         coef_sel,
  output logic [3:0]         coef_addr,
  input  logic signed [10:0] coef_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [11:0] out_data,
  output logic [2:0]         out_idx
);
  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

  state_t              state, state_nxt;
  logic [2:0]          n, k, idx;
  logic [3:0]          cyc;
  logic signed [21:0]  acc, acc_sum;
  logic signed [7:0]   smp [8];
  logic signed [7:0]   smp_in;
  logic signed [18:0]  prod;
  logic signed [22:0]  rnd;
  logic signed [13:0]  q;
  logic signed [11:0]  sat;

`ifdef DCT_LEVEL_SHIFT_EN
  assign smp_in = in_data - 8'd128;
`else
  assign smp_in = in_data;
`endif

  // coef_data arriving in cycle c belongs to address c-1 (registered ROM)
  assign idx     = cyc[2:0] - 3'd1;
  assign prod    = smp[idx] * coef_data;
  assign acc_sum = acc + $signed({{3{prod[18]}}, prod});
  assign rnd     = $signed({acc_sum[21], acc_sum}) + 23'sd256;
  assign q       = rnd[22:9];
  assign sat     = (q > 14'sd2047)  ? 12'sd2047 :
                   (q < -14'sd2048) ? -12'sd2048 : q[11:0];

  assign coef_sel  = k;
  assign coef_addr = (state == CALC && !cyc[3]) ? {1'b0, cyc[2:0]} : 4'd0;
  assign out_idx   = k;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && n == 3'd7) state_nxt = CALC;
      end
      CALC: if (cyc == 4'd8) state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = (k == 3'd7) ? LOAD : CALC;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n        <= 3'd0;
      k        <= 3'd0;
      cyc      <= 4'd0;
      acc      <= 22'sd0;
      out_data <= 12'sd0;
      for (int i = 0; i < 8; i++) smp[i] <= 8'sd0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          smp[n] <= smp_in;
          n      <= n + 3'd1;
          if (n == 3'd7) begin
            k   <= 3'd0;
            cyc <= 4'd0;
            acc <= 22'sd0;
          end
        end
        CALC: begin
          cyc <= cyc + 4'd1;
          if (cyc != 4'd0) acc <= acc_sum;
          if (cyc == 4'd8) out_data <= sat;
        end
        OUT: if (out_ready) begin
          if (k == 3'd7) begin
            k <= 3'd0;
            n <= 3'd0;
          end else begin
            k <= k + 3'd1;
          end
          cyc <= 4'd0;
          acc <= 22'sd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dct_row_mac.sv
// Self-checking bench for dct_row_mac: randomized rows against a plain DCT-sum reference.
module tb_dct_row_mac;
  logic               clk = 0;
  logic               rst_n;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic [2:0]         coef_sel;
  logic [3:0]         coef_addr;
  logic signed [10:0] coef_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [11:0] out_data;
  logic [2:0]         out_idx;

  int total = 0;
  int bad   = 0;
  int tab [8][8];
  bit rom_const;
  int rom_val;

  dct_row_mac dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .coef_sel(coef_sel), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  function automatic int coef(input int sel, input int addr);
    return rom_const ? rom_val : tab[sel][addr];
  endfunction

  // registered ROM: data appears one cycle after the address
  always @(posedge clk) coef_data <= 11'(coef(int'(coef_sel), int'(coef_addr[2:0])));

  function automatic int samp(input int px);
`ifdef DCT_LEVEL_SHIFT_EN
    return px - 128;
`else
    return (px > 127) ? px - 256 : px;
`endif
  endfunction

  function automatic int ref_out(input int px[8], input int k);
    int sum = 0;
    int r;
    for (int i = 0; i < 8; i++) sum += samp(px[i]) * coef(k, i);
    r = (sum + 256) >>> 9;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return r;
  endfunction

  task automatic send_row(input int px[8], input bit gaps);
    int i = 0;
    int t = 0;
    while (i < 8 && t < 200) begin
      @(negedge clk); t++;
      if (!gaps || ($urandom % 3) != 0) begin
        in_valid = 1'b1;
        in_data  = 8'(px[i]);
        if (in_ready) i++;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    total++;
    if (i != 8) begin bad++; $display("FAIL send_timeout accepted=%0d want=8", i); end
  endtask

  task automatic collect_row(input int exp[8], input int nres, input int stall_k, input bit garbage);
    for (int k = 0; k < nres; k++) begin
      int lat = 0;
      bit seen = 0;
      bit busy_ok = 1;
      while (!seen && lat < 40) begin
        @(negedge clk); lat++;
        if (out_valid) seen = 1;
        else begin
          if (in_ready !== 1'b0) busy_ok = 0;
          in_valid = garbage ? 1'($urandom) : 1'b0;
          in_data  = 8'($urandom);
        end
      end
      in_valid = 1'b0;
      total++;
      if (!busy_ok) begin bad++; $display("FAIL in_ready_busy k=%0d got=1 want=0", k); end
      total++;
      if (lat != 10) begin bad++; $display("FAIL latency k=%0d got=%0d want=10", k, lat); end
      total++;
      if (out_idx !== 3'(k)) begin bad++; $display("FAIL out_idx got=%0d want=%0d", out_idx, k); end
      total++;
      if (out_data !== 12'(exp[k]))
        begin bad++; $display("FAIL out_data k=%0d got=%0d want=%0d", k, out_data, exp[k]); end
      if (k == stall_k) begin
        logic [11:0] d0 = out_data;
        bit stable = 1;
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (out_valid !== 1'b1 || out_data !== d0 || out_idx !== 3'(k) || in_ready !== 1'b0)
            stable = 0;
          in_valid = 1'($urandom);
        end
        total++;
        if (!stable) begin bad++; $display("FAIL stall_hold k=%0d got=unstable want=stable", k); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
    end
  endtask

  task automatic run_row(input int px[8], input int stall_k, input bit gaps);
    int exp [8];
    for (int k = 0; k < 8; k++) exp[k] = ref_out(px, k);
    send_row(px, gaps);
    collect_row(exp, 8, stall_k, gaps);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL back_to_load got=%b want=1", in_ready); end
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'sd0 || out_idx !== 3'd0 ||
        coef_sel !== 3'd0 || coef_addr !== 4'd0) begin
      bad++;
      $display("FAIL %s got=rdy%b vld%b data%0d idx%0d sel%0d addr%0d want=rdy1 vld0 data0 idx0 sel0 addr0",
               tag, in_ready, out_valid, out_data, out_idx, coef_sel, coef_addr);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    #12;
    check_reset_vals("reset_values");
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random_rows;
    int px [8];
    rom_const = 0;
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++) tab[a][b] = int'($urandom_range(0, 2047)) - 1024;
      for (int i = 0; i < 8; i++) px[i] = int'($urandom_range(0, 255));
      run_row(px, -1, 1'b1);
    end
  endtask

  task automatic test_back_to_back;
    int px [8];
    for (int i = 0; i < 8; i++) px[i] = int'($urandom_range(0, 255));
    run_row(px, -1, 1'b0);
    for (int i = 0; i < 8; i++) px[i] = int'($urandom_range(0, 255));
    run_row(px, -1, 1'b0);
  endtask

  task automatic test_stall;
    int px [8];
    for (int i = 0; i < 8; i++) px[i] = int'($urandom_range(0, 255));
    run_row(px, 2, 1'b1);
  endtask

  // constant ROM of 362 with uniform rows; sample values 127, -128 and 0
  task automatic test_known_values;
    int px [8];
    int exp [8];
    int raw [3];
    int want [3];
`ifdef DCT_LEVEL_SHIFT_EN
    raw = '{255, 0, 128};
`else
    raw = '{127, 128, 0};
`endif
    want = '{718, -724, 0};
    rom_const = 1; rom_val = 362;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 8; i++) begin px[i] = raw[t]; exp[i] = want[t]; end
      send_row(px, 1'b0);
      collect_row(exp, 8, -1, 1'b0);
    end
  endtask

  task automatic test_saturation;
    int px [8];
    int exp [8];
    int neg;
`ifdef DCT_LEVEL_SHIFT_EN
    neg = 0;
`else
    neg = 128;
`endif
    rom_const = 1; rom_val = -1024;
    for (int i = 0; i < 8; i++) begin px[i] = neg; exp[i] = 2047; end
    send_row(px, 1'b0);
    collect_row(exp, 8, -1, 1'b0);
    rom_val = 1023;
    for (int i = 0; i < 8; i++) exp[i] = ref_out(px, i);
    send_row(px, 1'b0);
    collect_row(exp, 8, -1, 1'b0);
    rom_val = -1024;
    for (int i = 0; i < 8; i++) px[i] = 127 + (neg == 0 ? 128 : 0);
    for (int i = 0; i < 8; i++) exp[i] = -2048 + ((ref_out(px, i) != -2048) ? 0 : 0);
    for (int i = 0; i < 8; i++) exp[i] = ref_out(px, i);
    send_row(px, 1'b0);
    collect_row(exp, 8, -1, 1'b0);
  endtask

  task automatic test_reset_mid_calc;
    int px [8];
    int exp [8];
    bit quiet = 1;
    rom_const = 0;
    for (int i = 0; i < 8; i++) px[i] = int'($urandom_range(0, 255));
    for (int k = 0; k < 8; k++) exp[k] = ref_out(px, k);
    send_row(px, 1'b0);
    collect_row(exp, 3, -1, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset_mid_calc");
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL post_reset_quiet got=valid want=idle"); end
    for (int i = 0; i < 8; i++) px[i] = int'($urandom_range(0, 255));
    run_row(px, -1, 1'b1);
  endtask

  initial begin
    test_reset;
    test_random_rows;
    test_back_to_back;
    test_stall;
    test_known_values;
    test_saturation;
    test_reset_mid_calc;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
